stack_pointer_unit: RTL

Holds the main-stack pointer (MSP) and return-stack pointer (RSP) for the JALA stack CPU. It sits directly downstream of the multicycle control FSM and consumes its MSPop/MSPWrite/MSPRegReset and RSPop/RSPWrite/RSPRegReset strobes. It drives the stack addresses used by the memory-address muxes and tracks stack depth. Overflow and underflow are detected, blocked and latched as sticky faults.

---
 rtl/jala_stack_pkg.sv | 19 +
 rtl/stack_ptr_reg.sv | 89 ++++++++
 rtl/stack_pointer_unit.sv | 79 +++++++
 3 files changed

// File: rtl/jala_stack_pkg.sv
// Shared definitions for the JALA stack-pointer logic.
// Contents:
//   SP_WIDTH / SP_STEP  default pointer width and per-entry address step
//   SP_PUSH / SP_POP    direction encoding of the *Pop control strobes
//   cnt_width()         bit width needed to hold an entry count of 0..depth
package jala_stack_pkg;

   localparam int unsigned SP_WIDTH = 16;
   localparam int unsigned SP_STEP  = 2;

   localparam logic SP_PUSH = 1'b0;
   localparam logic SP_POP  = 1'b1;

   // A count must reach depth itself (full stack), hence the extra bit.
   function automatic int unsigned cnt_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/stack_ptr_reg.sv
// Single downward-growing stack pointer with entry counter and sticky faults.
// Ports:
//   i_clk        clock, rising edge
//   i_rst        synchronous active-high reset (empty stack, flags clear)
//   i_pop        direction: SP_POP = pointer += STEP, SP_PUSH = pointer -= STEP
//   i_write      update enable; i_pop is don't-care while low
//   i_reg_reset  reinitialise this stack to empty and clear its flags
//   o_ptr        current pointer (top-of-stack address)
//   o_count      current entry count, 0..DEPTH
//   o_ovf        sticky overflow (push attempted while full)
//   o_udf        sticky underflow (pop attempted while empty)
module stack_ptr_reg
   import jala_stack_pkg::*;
#(
   parameter int unsigned      WIDTH = SP_WIDTH,
   parameter int unsigned      STEP  = SP_STEP,
   parameter logic [WIDTH-1:0] BASE  = '1,
   parameter int unsigned      DEPTH = 64
) (
   input  logic                        i_clk,
   input  logic                        i_rst,
   input  logic                        i_pop,
   input  logic                        i_write,
   input  logic                        i_reg_reset,
   output logic [WIDTH-1:0]            o_ptr,
   output logic [cnt_width(DEPTH)-1:0] o_count,
   output logic                        o_ovf,
   output logic                        o_udf
);

   localparam int unsigned       CNT_W  = cnt_width(DEPTH);
   localparam logic [CNT_W-1:0]  FULL   = CNT_W'(DEPTH);
   localparam logic [WIDTH-1:0]  STEP_W = WIDTH'(STEP);

   logic [WIDTH-1:0] r_ptr, w_ptr_nxt;
   logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
   logic             r_ovf, w_ovf_nxt;
   logic             r_udf, w_udf_nxt;

   always_comb begin
      w_ptr_nxt = r_ptr;
      w_cnt_nxt = r_cnt;
      w_ovf_nxt = r_ovf;
      w_udf_nxt = r_udf;
      if (i_reg_reset) begin
         w_ptr_nxt = BASE;
         w_cnt_nxt = '0;
         w_ovf_nxt = 1'b0;
         w_udf_nxt = 1'b0;
      end else if (i_write) begin
         // i_pop is only looked at under i_write so an undriven pop cannot leak in.
         if (i_pop == SP_POP) begin
            if (r_cnt == '0) begin
               w_udf_nxt = 1'b1;
            end else begin
               w_ptr_nxt = r_ptr + STEP_W;
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end else begin
            if (r_cnt == FULL) begin
               w_ovf_nxt = 1'b1;
            end else begin
               w_ptr_nxt = r_ptr - STEP_W;
               w_cnt_nxt = r_cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_ptr <= BASE;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_udf <= 1'b0;
      end else begin
         r_ptr <= w_ptr_nxt;
         r_cnt <= w_cnt_nxt;
         r_ovf <= w_ovf_nxt;
         r_udf <= w_udf_nxt;
      end
   end

   assign o_ptr   = r_ptr;
   assign o_count = r_cnt;
   assign o_ovf   = r_ovf;
   assign o_udf   = r_udf;

endmodule

// File: rtl/stack_pointer_unit.sv
// Main-stack and return-stack pointers for the JALA stack CPU.
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   MSPop/MSPWrite/MSPRegReset  main-stack direction, update enable, reinitialise
//   RSPop/RSPWrite/RSPRegReset  return-stack direction, update enable, reinitialise
//   msp, rsp                  registered stack pointers
//   msp_next                  msp + STEP (second-entry address), combinational
//   ms_count, rs_count        registered entry counts
//   ms_ovf/ms_udf/rs_ovf/rs_udf  sticky fault flags
//   fault                     OR of the four sticky flags
// The two stacks are independent and may update in the same cycle.
module stack_pointer_unit
   import jala_stack_pkg::*;
#(
   parameter int unsigned      WIDTH    = SP_WIDTH,
   parameter int unsigned      STEP     = SP_STEP,
   parameter logic [WIDTH-1:0] MS_BASE  = 16'h7FFE,
   parameter int unsigned      MS_DEPTH = 256,
   parameter logic [WIDTH-1:0] RS_BASE  = 16'hFFFE,
   parameter int unsigned      RS_DEPTH = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           MSPop,
   input  logic                           MSPWrite,
   input  logic                           MSPRegReset,
   input  logic                           RSPop,
   input  logic                           RSPWrite,
   input  logic                           RSPRegReset,
   output logic [WIDTH-1:0]               msp,
   output logic [WIDTH-1:0]               msp_next,
   output logic [WIDTH-1:0]               rsp,
   output logic [cnt_width(MS_DEPTH)-1:0] ms_count,
   output logic [cnt_width(RS_DEPTH)-1:0] rs_count,
   output logic                           ms_ovf,
   output logic                           ms_udf,
   output logic                           rs_ovf,
   output logic                           rs_udf,
   output logic                           fault
);

   stack_ptr_reg #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .BASE  (MS_BASE),
      .DEPTH (MS_DEPTH)
   ) u_main (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pop       (MSPop),
      .i_write     (MSPWrite),
      .i_reg_reset (MSPRegReset),
      .o_ptr       (msp),
      .o_count     (ms_count),
      .o_ovf       (ms_ovf),
      .o_udf       (ms_udf)
   );

   stack_ptr_reg #(
      .WIDTH (WIDTH),
      .STEP  (STEP),
      .BASE  (RS_BASE),
      .DEPTH (RS_DEPTH)
   ) u_ret (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_pop       (RSPop),
      .i_write     (RSPWrite),
      .i_reg_reset (RSPRegReset),
      .o_ptr       (rsp),
      .o_count     (rs_count),
      .o_ovf       (rs_ovf),
      .o_udf       (rs_udf)
   );

   assign msp_next = msp + WIDTH'(STEP);
   assign fault    = ms_ovf | ms_udf | rs_ovf | rs_udf;

endmodule
